ks_sched_ctrl: RTL and testbench

- Sequencing controller for the chaotic-map keystream generator.
- Drives the key/IV register load strobe, the initial/feedback state select and the state-update enable.
- Runs a fixed number of warm-up (discard) iterations, then delivers keystream words through a one-word output buffer with valid/ready backpressure.
- Stops after a programmed word budget so the system can rekey.

---
 rtl/ks_ctrl_pkg.sv | 18 +
 rtl/ks_out_buf.sv | 41 ++++
 rtl/ks_sched_ctrl.sv | 120 ++++++++++++
 tb/tb_ks_sched_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_ctrl_pkg.sv
// Shared definitions for the keystream sequencing controller:
// FSM state encoding, default session constants and the word width.
package ks_ctrl_pkg;

  localparam int KS_W          = 32;
  localparam int DEF_WARMUP    = 4;
  localparam int DEF_MAX_WORDS = 1024;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEED = 3'd2,
    WARM = 3'd3,
    RUN  = 3'd4,
    DONE = 3'd5
  } ks_state_e;

endpackage

// File: rtl/ks_out_buf.sv
// One-word keystream output buffer with valid/ready backpressure.
// Handshake: a word moves to the consumer on any cycle where valid=1 and
// ready=1 (take). valid stays high and data stays frozen until that happens.
// fill tells the controller the buffer captures din this cycle, which is also
// the cycle the generator must advance.
module ks_out_buf
  import ks_ctrl_pkg::*;
#(
  parameter int W = KS_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic         room,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         fill,
  output logic         take
);

  assign take = valid & ready;
  // Capture only in RUN, only while the session still has budget, and only
  // when the slot is empty or being emptied this cycle.
  assign fill = run & (~valid | take) & room;

  // Buffer register: capture on fill, drop valid on a take with no refill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (fill) begin
      data  <= din;
      valid <= 1'b1;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ks_sched_ctrl.sv
// Sequencing controller for the chaotic-map keystream generator: loads
// key/IV, seeds the state, discards WARMUP iterations, then streams up to
// MAX_WORDS words through a one-word valid/ready buffer before returning
// to IDLE for a rekey.
module ks_sched_ctrl
  import ks_ctrl_pkg::*;
#(
  parameter int WARMUP    = DEF_WARMUP,
  parameter int WC_W      = 3,
  parameter int MAX_WORDS = DEF_MAX_WORDS,
  parameter int MW_W      = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [KS_W-1:0] ks_in,
  input  logic            ks_ready,
  output logic            read0,
  output logic            s,
  output logic            en1,
  output logic [KS_W-1:0] ks_data,
  output logic            ks_valid,
  output logic            busy,
  output logic            done,
  output logic [MW_W-1:0] word_cnt,
  output logic [2:0]      state
);

  ks_state_e       state_q;
  ks_state_e       state_d;
  logic [WC_W-1:0] warm_cnt;
  logic [MW_W-1:0] issued;
  logic            in_run;
  logic            room;
  logic            fill;
  logic            take;
  logic            last_take;
  logic            start_ok;

  assign in_run    = (state_q == RUN);
  assign room      = (issued < MW_W'(MAX_WORDS));
  assign last_take = take & (word_cnt == MW_W'(MAX_WORDS - 1));
  assign start_ok  = (state_q == IDLE) & start;
  assign state     = state_q;

  ks_out_buf #(.W(KS_W)) u_out_buf (
    .clk   (clk),
    .reset (reset),
    .run   (in_run),
    .room  (room),
    .din   (ks_in),
    .ready (ks_ready),
    .data  (ks_data),
    .valid (ks_valid),
    .fill  (fill),
    .take  (take)
  );

  // Datapath strobes decode straight from state; en1 in RUN follows fill so
  // a stalled buffer freezes the generator.
  always_comb begin
    read0 = (state_q == LOAD);
    s     = (state_q == WARM) | (state_q == RUN);
    en1   = (state_q == SEED) | (state_q == WARM) | (in_run & fill);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SEED;
      SEED:    state_d = WARM;
      WARM:    if (warm_cnt == WC_W'(WARMUP - 1)) state_d = RUN;
      RUN:     if (last_take) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus registered busy/done flags derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
    end
  end

  // Warm-up counter: cleared while seeding, counts discarded iterations.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warm_cnt <= '0;
    end else if (state_q == SEED) begin
      warm_cnt <= '0;
    end else if (state_q == WARM) begin
      warm_cnt <= warm_cnt + WC_W'(1);
    end
  end

  // Session counters: issued counts captures, word_cnt counts consumer takes.
  // Both clear on an accepted start and hold after the session ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued   <= '0;
      word_cnt <= '0;
    end else if (start_ok) begin
      issued   <= '0;
      word_cnt <= '0;
    end else begin
      if (fill) issued   <= issued + MW_W'(1);
      if (take) word_cnt <= word_cnt + MW_W'(1);
    end
  end

endmodule

// File: tb/tb_ks_sched_ctrl.sv
// Self-checking bench for ks_sched_ctrl. A small generator model advances on
// en1 (seed load when s=0, +1 when s=1), so the words a consumer should see are
// seed+WARMUP, seed+WARMUP+1, ... regardless of backpressure.
module tb_ks_sched_ctrl;
  import ks_ctrl_pkg::*;

  localparam int WARMUP = 4;
  localparam int WC_W   = 3;
  localparam int MAXW   = 3;
  localparam int MW_W   = 2;
  localparam int W      = 32;
  localparam int TMAX   = 128;
  localparam int FIRST_VALID = 1 + WARMUP + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic            ks_ready = 1'b0;
  logic [W-1:0]    ks_in;
  logic            read0, s, en1, ks_valid, busy, done;
  logic [W-1:0]    ks_data;
  logic [MW_W-1:0] word_cnt;
  logic [2:0]      state;

  int checks = 0;
  int errors = 0;

  ks_sched_ctrl #(
    .WARMUP(WARMUP), .WC_W(WC_W), .MAX_WORDS(MAXW), .MW_W(MW_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ks_in(ks_in), .ks_ready(ks_ready),
    .read0(read0), .s(s), .en1(en1), .ks_data(ks_data), .ks_valid(ks_valid),
    .busy(busy), .done(done), .word_cnt(word_cnt), .state(state)
  );

  // ---------------- generator model ----------------
  logic [W-1:0] gen = '0;
  logic [W-1:0] seed_val = '0;
  logic         en1_n = 1'b0;
  logic         s_n = 1'b0;
  assign ks_in = gen;
  always @(negedge clk) begin
    en1_n <= en1;
    s_n   <= s;
  end
  always @(posedge clk) begin
    if (en1_n) gen <= s_n ? gen + 32'd1 : seed_val;
  end

  // ---------------- session trace ----------------
  bit              tr_read0 [TMAX];
  bit              tr_s     [TMAX];
  bit              tr_en1   [TMAX];
  bit              tr_valid [TMAX];
  bit              tr_ready [TMAX];
  bit              tr_done  [TMAX];
  bit              tr_busy  [TMAX];
  logic [W-1:0]    tr_data  [TMAX];
  logic [MW_W-1:0] tr_wcnt  [TMAX];
  logic [2:0]      tr_state [TMAX];
  logic [W-1:0]    got_q[$];
  logic [W-1:0]    exp_q[$];
  int              ncyc;
  int              done_at;

  // ready_mode: 0 = always ready, 1 = random 50%.
  // start_mode: 0 = single pulse, 1 = extra pulses in WARM/RUN, 2 = held from cycle 5.
  task automatic run_session(input int ready_mode, input int start_mode);
    ncyc    = 0;
    done_at = -1;
    got_q.delete();
    exp_q.delete();
    seed_val = $urandom;
    for (int k = 0; k < MAXW; k++) exp_q.push_back(seed_val + W'(WARMUP + k));
    @(posedge clk); #1;
    start    = 1'b1;
    ks_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    for (int c = 0; c < TMAX; c++) begin
      @(negedge clk);
      tr_read0[c] = read0;  tr_s[c] = s;        tr_en1[c] = en1;
      tr_valid[c] = ks_valid; tr_ready[c] = ks_ready;
      tr_done[c]  = done;   tr_busy[c] = busy;  tr_data[c] = ks_data;
      tr_wcnt[c]  = word_cnt; tr_state[c] = state;
      if (ks_valid && ks_ready) got_q.push_back(ks_data);
      ncyc = c + 1;
      if (done && done_at < 0) done_at = c;
      if (done_at >= 0 && c == done_at + 2) break;
      @(posedge clk); #1;
      case (start_mode)
        1:       start = (c + 1 == 4) || (c + 1 == 9) || (c + 1 == 10);
        2:       start = (c + 1 >= 5);
        default: start = 1'b0;
      endcase
      ks_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; start = 1'b0; ks_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({read0, s, en1, ks_valid, busy, done} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes got=%b exp=000000", {read0, s, en1, ks_valid, busy, done});
    end
    checks++;
    if (ks_data !== '0 || word_cnt !== '0) begin
      errors++; $display("FAIL reset_regs data=%h wcnt=%0d exp=0/0", ks_data, word_cnt);
    end
    checks++;
    if (state !== IDLE) begin
      errors++; $display("FAIL reset_state got=%0d exp=%0d", state, IDLE);
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || state !== IDLE || en1 !== 1'b0) begin
      errors++; $display("FAIL idle_no_start busy=%b state=%0d en1=%b exp=0/0/0", busy, state, en1);
    end
  endtask

  task automatic test_startup();
    int n_read0, n_seed, n_warm, n_run_en1, first_v;
    run_session(0, 0);
    checks++;
    if (done_at < 0) begin
      errors++; $display("FAIL startup_timeout got=no_done exp=done"); return;
    end
    n_read0 = 0; n_seed = 0; n_warm = 0; n_run_en1 = 0; first_v = -1;
    for (int c = 0; c < ncyc; c++) if (tr_valid[c] && first_v < 0) first_v = c;
    for (int c = 0; c < ncyc; c++) begin
      n_read0 += int'(tr_read0[c]);
      n_seed  += int'(tr_en1[c] && !tr_s[c]);
      if (c < first_v - 1) n_warm += int'(tr_en1[c] && tr_s[c]);
      else n_run_en1 += int'(tr_en1[c]);
    end
    checks++;
    if (n_read0 != 1 || !tr_read0[1]) begin
      errors++; $display("FAIL startup_read0 count=%0d at1=%b exp=1/1", n_read0, tr_read0[1]);
    end
    checks++;
    if (n_seed != 1 || !(tr_en1[2] && !tr_s[2])) begin
      errors++; $display("FAIL startup_seed count=%0d exp=1 at cycle 2", n_seed);
    end
    checks++;
    if (first_v != FIRST_VALID) begin
      errors++; $display("FAIL first_valid got=%0d exp=%0d", first_v, FIRST_VALID);
    end
    checks++;
    if (n_warm != WARMUP) begin
      errors++; $display("FAIL warm_en1 got=%0d exp=%0d", n_warm, WARMUP);
    end
    checks++;
    if (n_run_en1 != MAXW) begin
      errors++; $display("FAIL run_captures got=%0d exp=%0d", n_run_en1, MAXW);
    end
    checks++;
    if (got_q != exp_q) begin
      errors++; $display("FAIL startup_words got_n=%0d exp_n=%0d first=%h exp_first=%h",
                         got_q.size(), exp_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
    end
    for (int k = 0; k < MAXW; k++) begin
      checks++;
      if (!tr_valid[FIRST_VALID + k] || tr_wcnt[FIRST_VALID + k] !== MW_W'(k)) begin
        errors++; $display("FAIL stream_cycle%0d valid=%b wcnt=%0d exp=1/%0d",
                           k, tr_valid[FIRST_VALID + k], tr_wcnt[FIRST_VALID + k], k);
      end
    end
    checks++;
    if (done_at != FIRST_VALID + MAXW || tr_wcnt[done_at] !== MW_W'(MAXW)) begin
      errors++; $display("FAIL done_timing at=%0d wcnt=%0d exp=%0d/%0d", done_at, tr_wcnt[done_at],
                         FIRST_VALID + MAXW, MAXW);
    end
    checks++;
    if (!tr_busy[done_at] || tr_busy[done_at + 1] || tr_done[done_at + 1] || tr_en1[done_at]) begin
      errors++; $display("FAIL done_tail busy=%b%b done_next=%b en1=%b exp=10/0/0",
                         tr_busy[done_at], tr_busy[done_at + 1], tr_done[done_at + 1], tr_en1[done_at]);
    end
    checks++;
    if (tr_wcnt[done_at + 2] !== MW_W'(MAXW) || tr_read0[done_at + 2] || tr_busy[0] || !tr_busy[1]) begin
      errors++; $display("FAIL idle_hold wcnt=%0d read0=%b busy0=%b busy1=%b exp=%0d/0/0/1",
                         tr_wcnt[done_at + 2], tr_read0[done_at + 2], tr_busy[0], tr_busy[1], MAXW);
    end
  endtask

  task automatic test_backpressure();
    for (int sess = 0; sess < 15; sess++) begin
      run_session(1, 0);
      checks++;
      if (done_at < 0) begin
        errors++; $display("FAIL bp_timeout session=%0d", sess); return;
      end
      checks++;
      if (got_q != exp_q) begin
        errors++; $display("FAIL bp_words session=%0d got_n=%0d exp_n=%0d", sess, got_q.size(), exp_q.size());
      end
      checks++;
      if (tr_wcnt[done_at] !== MW_W'(MAXW)) begin
        errors++; $display("FAIL bp_wcnt session=%0d got=%0d exp=%0d", sess, tr_wcnt[done_at], MAXW);
      end
      for (int c = 1; c < ncyc; c++) begin
        if (tr_valid[c - 1] && !tr_ready[c - 1]) begin
          checks++;
          if (!tr_valid[c] || tr_data[c] !== tr_data[c - 1]) begin
            errors++; $display("FAIL bp_hold cycle=%0d data=%h valid=%b exp=%h/1", c, tr_data[c], tr_valid[c], tr_data[c - 1]);
          end
        end
        if (tr_valid[c] && !tr_ready[c]) begin
          checks++;
          if (tr_en1[c]) begin
            errors++; $display("FAIL bp_en1 cycle=%0d got=1 exp=0", c);
          end
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int n_read0;
    run_session(0, 1);
    checks++;
    if (done_at < 0) begin
      errors++; $display("FAIL ign_timeout got=no_done exp=done"); return;
    end
    n_read0 = 0;
    for (int c = 0; c <= done_at + 2; c++) n_read0 += int'(tr_read0[c]);
    checks++;
    if (n_read0 != 1 || done_at != FIRST_VALID + MAXW || got_q != exp_q) begin
      errors++; $display("FAIL start_ignored read0=%0d done_at=%0d words=%0d exp=1/%0d/%0d",
                         n_read0, done_at, got_q.size(), FIRST_VALID + MAXW, MAXW);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    run_session(0, 2);
    checks++;
    if (done_at < 0) begin
      errors++; $display("FAIL b2b_timeout got=no_done exp=done"); return;
    end
    checks++;
    if (tr_state[done_at + 1] !== IDLE || tr_wcnt[done_at + 1] !== MW_W'(MAXW)) begin
      errors++; $display("FAIL b2b_idle state=%0d wcnt=%0d exp=%0d/%0d", tr_state[done_at + 1],
                         tr_wcnt[done_at + 1], IDLE, MAXW);
    end
    checks++;
    if (!tr_read0[done_at + 2] || tr_wcnt[done_at + 2] !== '0 || !tr_busy[done_at + 2]) begin
      errors++; $display("FAIL b2b_relaunch read0=%b wcnt=%0d busy=%b exp=1/0/1",
                         tr_read0[done_at + 2], tr_wcnt[done_at + 2], tr_busy[done_at + 2]);
    end
    seen = 1'b0;
    ks_ready = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL b2b_second_session got=no_done exp=done");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    bit seen_v;
    bit bad;
    seen_v = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; ks_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 30 && !seen_v; c++) begin
      @(negedge clk);
      if (ks_valid) seen_v = 1'b1;
    end
    checks++;
    if (!seen_v) begin
      errors++; $display("FAIL rst_mid_reach got=no_valid exp=valid");
    end
    @(posedge clk); #1 reset = 1'b0;
    #1;
    checks++;
    if ({read0, s, en1, ks_valid, busy, done} !== 6'b0 || word_cnt !== '0 || ks_data !== '0) begin
      errors++; $display("FAIL rst_mid_immediate got=%b wcnt=%0d data=%h exp=0",
                         {read0, s, en1, ks_valid, busy, done}, word_cnt, ks_data);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    bad = 1'b0;
    ks_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ks_valid || done || busy || en1 || state !== IDLE) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL rst_mid_after got=activity exp=idle");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_startup();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
